// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave endpoint: data width limit,
// FSM state encoding and the word-width clamp helper.
package spi_pkg;

   localparam int SPI_DATA_MAX = 32;

   typedef enum logic {
      IDLE,
      ACTIVE
   } spi_slave_state_t;

   // Widths of 0 or above 32 select a full 32-bit word.
   function automatic logic [5:0] spi_eff_width(input logic [5:0] dw);
      if (dw == 6'd0 || dw > 6'd32) begin
         return 6'd32;
      end
      return dw;
   endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer with a third register for edge detection.
// Ports: clk, rst_n, d_i (async input), q_o (synced level),
//        rise_o / fall_o (one-cycle pulses on synced transitions).
module spi_slave_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic       s1_q;
   logic       s2_q;
   logic       s3_q;
   logic [2:0] vld_q;

   // vld_q tracks how far real samples have travelled down the chain,
   // so the reset value never produces an edge against a live level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q  <= RST_VAL;
         s2_q  <= RST_VAL;
         s3_q  <= RST_VAL;
         vld_q <= 3'b000;
      end else begin
         s1_q  <= d_i;
         s2_q  <= s1_q;
         s3_q  <= s2_q;
         vld_q <= {vld_q[1:0], 1'b1};
      end
   end

   assign q_o    = s2_q;
   assign rise_o = vld_q[2] & s2_q & ~s3_q;
   assign fall_o = vld_q[2] & ~s2_q & s3_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversampled cs/sck/mosi, all cpol/cpha modes,
// 1-32 bit words, AXI-Stream rx output and tx input.
// Ports: clk, rst_n; cpol, cpha, data_width (latched per frame);
//        s_axis_* tx words in; m_axis_* rx words out;
//        cs, sck, mosi, miso, miso_oe bus; overrun / underrun pulses.
// Optional: define SPI_SLAVE_ERR_CNT_EN to add saturating
//        overrun_cnt / underrun_cnt error counters.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_MAX = SPI_DATA_MAX
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpol,
   input  logic                cpha,
   input  logic [5:0]          data_width,
   input  logic [DATA_MAX-1:0] s_axis_tdata,
   input  logic                s_axis_tvalid,
   output logic                s_axis_tready,
   output logic [DATA_MAX-1:0] m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   input  logic                cs,
   input  logic                sck,
   input  logic                mosi,
   output logic                miso,
   output logic                miso_oe,
   output logic                overrun,
   output logic                underrun
`ifdef SPI_SLAVE_ERR_CNT_EN
   ,
   output logic [15:0]         overrun_cnt,
   output logic [15:0]         underrun_cnt
`endif
);

   spi_slave_state_t    state_q, state_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic [5:0]          width_q, width_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [DATA_MAX-1:0] tx_q, tx_d;
   logic [DATA_MAX-1:0] rx_q, rx_d;
   logic [DATA_MAX-1:0] hold_q, hold_d;
   logic                hold_vld_q, hold_vld_d;
   logic [DATA_MAX-1:0] mdata_q, mdata_d;
   logic                mvld_q, mvld_d;
   logic                tx_empty_q, tx_empty_d;
   logic                ovr_q, ovr_d;
   logic                udr_q, udr_d;
   logic                miso_q, miso_d;
   logic                load;

   logic cs_lvl_unused, cs_rise, cs_fall;
   logic sck_lvl_unused, sck_rise, sck_fall;
   logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;
   logic lead, trail, sample, shift;
   logic [4:0] msb_idx;

   spi_slave_sync #(.RST_VAL(1'b1)) u_cs_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (cs),
      .q_o    (cs_lvl_unused),
      .rise_o (cs_rise),
      .fall_o (cs_fall)
   );

   spi_slave_sync #(.RST_VAL(1'b0)) u_sck_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (sck),
      .q_o    (sck_lvl_unused),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   spi_slave_sync #(.RST_VAL(1'b0)) u_mosi_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (mosi),
      .q_o    (mosi_lvl),
      .rise_o (mosi_rise_unused),
      .fall_o (mosi_fall_unused)
   );

   assign lead    = cpol_q ? sck_fall : sck_rise;
   assign trail   = cpol_q ? sck_rise : sck_fall;
   assign sample  = cpha_q ? trail : lead;
   assign shift   = cpha_q ? lead : trail;
   assign msb_idx = 5'(width_q - 6'd1);

   always_comb begin
      state_d    = state_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      width_d    = width_q;
      cnt_d      = cnt_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      mdata_d    = mdata_q;
      mvld_d     = mvld_q;
      tx_empty_d = tx_empty_q;
      ovr_d      = 1'b0;
      udr_d      = 1'b0;
      load       = 1'b0;

      if (s_axis_tvalid && !hold_vld_q) begin
         hold_d     = s_axis_tdata;
         hold_vld_d = 1'b1;
      end

      if (mvld_q && m_axis_tready) begin
         mvld_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d = ACTIVE;
               cpol_d  = cpol;
               cpha_d  = cpha;
               width_d = spi_eff_width(data_width);
               cnt_d   = 6'd0;
               rx_d    = '0;
               load    = 1'b1;
            end
         end
         ACTIVE: begin
            if (cnt_q == width_q) begin
               if (mvld_q && !m_axis_tready) begin
                  ovr_d = 1'b1;
               end else begin
                  mdata_d = rx_q;
                  mvld_d  = 1'b1;
               end
               cnt_d = 6'd0;
               rx_d  = '0;
               load  = 1'b1;
            end else if (sample) begin
               rx_d  = {rx_q[DATA_MAX-2:0], mosi_lvl};
               cnt_d = cnt_q + 6'd1;
               // Flag a data-less word once it actually starts.
               if (cnt_q == 6'd0 && tx_empty_q) begin
                  udr_d      = 1'b1;
                  tx_empty_d = 1'b0;
               end
            end else if (shift && cnt_q != 6'd0) begin
               // At bit 0 the freshly loaded MSB is already on miso.
               tx_d = {tx_q[DATA_MAX-2:0], 1'b0};
            end
            if (cs_rise) begin
               state_d    = IDLE;
               cnt_d      = 6'd0;
               rx_d       = '0;
               tx_empty_d = 1'b0;
               udr_d      = 1'b0;
            end
         end
      endcase

      if (load) begin
         if (hold_vld_q) begin
            tx_d       = hold_q;
            hold_vld_d = 1'b0;
            tx_empty_d = 1'b0;
         end else begin
            tx_d       = '0;
            tx_empty_d = 1'b1;
         end
      end

      miso_d = (state_q == ACTIVE) ? tx_q[msb_idx] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         width_q    <= 6'd32;
         cnt_q      <= 6'd0;
         tx_q       <= '0;
         rx_q       <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         mdata_q    <= '0;
         mvld_q     <= 1'b0;
         tx_empty_q <= 1'b0;
         ovr_q      <= 1'b0;
         udr_q      <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         width_q    <= width_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         mdata_q    <= mdata_d;
         mvld_q     <= mvld_d;
         tx_empty_q <= tx_empty_d;
         ovr_q      <= ovr_d;
         udr_q      <= udr_d;
         miso_q     <= miso_d;
      end
   end

   assign s_axis_tready = ~hold_vld_q;
   assign m_axis_tdata  = mdata_q;
   assign m_axis_tvalid = mvld_q;
   assign miso          = miso_q;
   assign miso_oe       = (state_q == ACTIVE);
   assign overrun       = ovr_q;
   assign underrun      = udr_q;

`ifdef SPI_SLAVE_ERR_CNT_EN
   logic [15:0] ovr_cnt_q, udr_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_cnt_q <= 16'd0;
         udr_cnt_q <= 16'd0;
      end else begin
         if (ovr_q && ovr_cnt_q != 16'hFFFF) begin
            ovr_cnt_q <= ovr_cnt_q + 16'd1;
         end
         if (udr_q && udr_cnt_q != 16'hFFFF) begin
            udr_cnt_q <= udr_cnt_q + 16'd1;
         end
      end
   end

   assign overrun_cnt  = ovr_cnt_q;
   assign underrun_cnt = udr_cnt_q;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bus master model drives frames,
// expected rx words are queued and checked by a separate monitor.
module tb_spi_slave;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpol = 1'b0;
   logic        cpha = 1'b0;
   logic [5:0]  data_width = 6'd8;
   logic [31:0] s_tdata = '0;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready = 1'b1;
   logic        cs = 1'b1;
   logic        sck = 1'b0;
   logic        mosi = 1'b0;
   logic        miso;
   logic        miso_oe;
   logic        overrun;
   logic        underrun;
`ifdef SPI_SLAVE_ERR_CNT_EN
   logic [15:0] overrun_cnt;
   logic [15:0] underrun_cnt;
`endif

   int n_chk = 0;
   int n_fail = 0;
   int ovr_seen = 0;
   int udr_seen = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   spi_slave dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cpol          (cpol),
      .cpha          (cpha),
      .data_width    (data_width),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .cs            (cs),
      .sck           (sck),
      .mosi          (mosi),
      .miso          (miso),
      .miso_oe       (miso_oe),
      .overrun       (overrun),
      .underrun      (underrun)
`ifdef SPI_SLAVE_ERR_CNT_EN
      ,
      .overrun_cnt   (overrun_cnt),
      .underrun_cnt  (underrun_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: flag pulses and pop the scoreboard on each rx handshake.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (overrun) ovr_seen++;
            if (underrun) udr_seen++;
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL rx_unexpected: got %h expected none",
                           m_tdata);
               end else begin
                  check("rx_word", m_tdata, exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timeout");
   end

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_tx(input logic [31:0] w);
      bit done;
      done = 1'b0;
      s_tdata = w;
      s_tvalid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (s_tready) done = 1'b1;
         @(negedge clk);
      end
      s_tvalid = 1'b0;
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL tx_push: got tready stuck low expected accept");
      end
   endtask

   task automatic frame_begin(input logic pol, input logic pha,
                              input logic [5:0] w);
      cpol = pol;
      cpha = pha;
      data_width = w;
      sck = pol;
      mosi = 1'b0;
      clks(6);
      cs = 1'b0;
      clks(10);
   endtask

   task automatic frame_end();
      clks(HALF);
      cs = 1'b1;
      clks(12);
   endtask

   // Send the top nbits of a w-bit word; return what miso carried.
   task automatic xfer(input int nbits, input int w,
                       input logic [31:0] tx, output logic [31:0] rx);
      int b;
      rx = '0;
      for (int k = 0; k < nbits; k++) begin
         b = w - 1 - k;
         if (!cpha) begin
            mosi = tx[b];
            clks(HALF);
            sck = ~cpol;
            rx = {rx[30:0], miso};
            clks(HALF);
            sck = cpol;
         end else begin
            sck = ~cpol;
            mosi = tx[b];
            clks(HALF);
            sck = cpol;
            rx = {rx[30:0], miso};
            clks(HALF);
         end
      end
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] r2;
      logic        pol;
      logic        pha;
      logic [5:0]  wcfg;

      clks(3);
      check("rst_tready", 32'(s_tready), 32'd1);
      check("rst_tvalid", 32'(m_tvalid), 32'd0);
      check("rst_tdata", m_tdata, 32'd0);
      check("rst_miso_oe", 32'(miso_oe), 32'd0);
      rst_n = 1'b1;
      clks(5);

      push_tx(32'hA5);
      exp_q.push_back(32'h3C);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(8, 8, 32'h3C, r);
      frame_end();
      check("mode0_miso", r, 32'hA5);

      for (int m = 1; m < 4; m++) begin
         pol = (m >= 2);
         pha = (m % 2) == 1;
         wcfg = (m == 3) ? 6'd0 : 6'd32;
         push_tx(32'h12345678);
         exp_q.push_back(32'hDEADBEEF);
         frame_begin(pol, pha, wcfg);
         xfer(32, 32, 32'hDEADBEEF, r);
         frame_end();
         check("mode123_miso", r, 32'h12345678);
      end
      check("mode_flags_ovr", 32'(ovr_seen), 32'd0);
      check("mode_flags_udr", 32'(udr_seen), 32'd0);

      push_tx(32'h5A5);
      exp_q.push_back(32'hABC);
      exp_q.push_back(32'h123);
      frame_begin(1'b0, 1'b0, 6'd12);
      xfer(12, 12, 32'hABC, r);
      xfer(12, 12, 32'h123, r2);
      frame_end();
      check("b2b_miso1", r, 32'h5A5);
      check("b2b_miso2", r2, 32'h0);
      check("b2b_underrun", 32'(udr_seen), 32'd1);

      m_tready = 1'b0;
      push_tx(32'h0F);
      exp_q.push_back(32'h11);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(8, 8, 32'h11, r);
      frame_end();
      check("ovr_miso1", r, 32'h0F);
      push_tx(32'hF0);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(8, 8, 32'h22, r);
      frame_end();
      check("ovr_miso2", r, 32'hF0);
      check("ovr_pulse", 32'(ovr_seen), 32'd1);
      check("ovr_hold_valid", 32'(m_tvalid), 32'd1);
      check("ovr_hold_data", m_tdata, 32'h11);
      m_tready = 1'b1;
      clks(4);

      push_tx(32'h99);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(5, 8, 32'hE0, r);
      frame_end();
      check("abort_miso", r, 32'h13);
      push_tx(32'h3F);
      exp_q.push_back(32'h77);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(8, 8, 32'h77, r);
      frame_end();
      check("abort_next_miso", r, 32'h3F);
      check("abort_flags_udr", 32'(udr_seen), 32'd1);
      check("abort_flags_ovr", 32'(ovr_seen), 32'd1);
`ifdef SPI_SLAVE_ERR_CNT_EN
      check("cnt_ovr", 32'(overrun_cnt), 32'd1);
      check("cnt_udr", 32'(underrun_cnt), 32'd1);
`endif

      push_tx(32'h55);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(4, 8, 32'hC3, r);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tready", 32'(s_tready), 32'd1);
      check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
      check("mid_rst_tdata", m_tdata, 32'd0);
      check("mid_rst_miso", 32'(miso), 32'd0);
      check("mid_rst_miso_oe", 32'(miso_oe), 32'd0);
      check("mid_rst_flags", 32'({overrun, underrun}), 32'd0);
`ifdef SPI_SLAVE_ERR_CNT_EN
      check("mid_rst_cnt", 32'({overrun_cnt, underrun_cnt}), 32'd0);
`endif
      clks(3);
      rst_n = 1'b1;
      clks(20);
      check("rst_cs_low_idle", 32'(miso_oe), 32'd0);
      cs = 1'b1;
      clks(12);
      push_tx(32'hE7);
      exp_q.push_back(32'h81);
      frame_begin(1'b0, 1'b0, 6'd8);
      xfer(8, 8, 32'h81, r);
      frame_end();
      check("post_rst_miso", r, 32'hE7);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
         clks(1);
      end
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("final_ovr", 32'(ovr_seen), 32'd1);
      check("final_udr", 32'(udr_seen), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
